// File: rtl/axi_helper_pkg.sv
// ---------------------------------------------------------------------------
// axi_helper : shared AXI-Lite beat types, response codes and FSM encodings
// Revision   : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package axi_helper;

  localparam int ADDR_LEN   = 32;
  localparam int DATA_LEN   = 64;
  localparam int WSTRB_LEN  = DATA_LEN / 8;
  localparam int BYTE_OFF_W = $clog2(WSTRB_LEN);

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef struct packed {
    logic [DATA_LEN-1:0]  data;
    logic [WSTRB_LEN-1:0] strb;
  } WxDATA_t;

  typedef struct packed {
    logic [DATA_LEN-1:0] data;
    resp_t               resp;
  } RxDATA_t;

  localparam int WxDATA_W = $bits(WxDATA_t);
  localparam int RxDATA_W = $bits(RxDATA_t);

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic [DATA_LEN-1:0] strb_merge(
    input logic [DATA_LEN-1:0] old,
    input WxDATA_t             beat
  );
    logic [DATA_LEN-1:0] merged;
    merged = old;
    for (int b = 0; b < WSTRB_LEN; b++) begin
      if (beat.strb[b]) merged[b*8 +: 8] = beat.data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axil_addr_decode.sv
// ---------------------------------------------------------------------------
// axil_addr_decode : byte address -> register index and AXI response
// Optional macro   : AXIL_ERR_CNT_EN (index NUM_REGS maps to the error counter)
// Revision         : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axil_addr_decode
  import axi_helper::*;
#(
  parameter int                  NUM_REGS  = 8,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                  IDX_W     = 3
) (
  input  logic [ADDR_LEN-1:0] addr,
  output logic [IDX_W-1:0]    idx,
  output logic                cnt_hit,
  output resp_t               resp
);

  localparam int FULL_W = ADDR_LEN - BYTE_OFF_W;
  localparam logic [FULL_W-1:0] C_NUM = FULL_W'(NUM_REGS);

  logic [ADDR_LEN:0]   off_ext;
  logic                below_base;
  logic [FULL_W-1:0]   full_idx;
  logic                misaligned;

  always_comb begin
    // The extra MSB of the subtraction is the borrow, i.e. addr < BASE_ADDR.
    off_ext    = {1'b0, addr} - {1'b0, BASE_ADDR};
    below_base = off_ext[ADDR_LEN];
    full_idx   = off_ext[ADDR_LEN-1:BYTE_OFF_W];
    misaligned = (off_ext[BYTE_OFF_W-1:0] != '0);
    idx        = full_idx[IDX_W-1:0];
    cnt_hit    = 1'b0;
    resp       = OKAY;
    if (below_base) begin
      resp = DECERR;
`ifdef AXIL_ERR_CNT_EN
    end else if (full_idx == C_NUM) begin
      cnt_hit = 1'b1;
      resp    = misaligned ? SLVERR : OKAY;
    end else if (full_idx > C_NUM) begin
      resp = DECERR;
`else
    end else if (full_idx >= C_NUM) begin
      resp = DECERR;
`endif
    end else if (misaligned) begin
      resp = SLVERR;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axil_slave_regfile.sv
// ---------------------------------------------------------------------------
// axil_slave_regfile : AXI-Lite slave terminating AW/W/B and AR/R into a bank
//                      of NUM_REGS byte-writable registers.
// Optional macro     : AXIL_ERR_CNT_EN (saturating SLVERR/DECERR counter)
// Revision           : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module axil_slave_regfile
  import axi_helper::*;
#(
  parameter int                  NUM_REGS  = 8,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_LEN-1:0]          AWADDR,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [WxDATA_W-1:0]          WDATA,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [ADDR_LEN-1:0]          ARADDR,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [RxDATA_W-1:0]          RDATA,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [NUM_REGS*DATA_LEN-1:0] reg_q,
  output logic [NUM_REGS-1:0]          reg_wr
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // ---------------- write path ----------------
  wr_state_t           wr_state_q, wr_state_d;
  logic [ADDR_LEN-1:0] awaddr_q, awaddr_d;
  WxDATA_t             wbeat_q, wbeat_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  resp_t               bresp_q, bresp_d;
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
  logic [DATA_LEN-1:0] regs_q [NUM_REGS];
  logic [DATA_LEN-1:0] regs_d [NUM_REGS];

  logic                aw_hs, w_hs, commit;
  logic [ADDR_LEN-1:0] wr_addr;
  WxDATA_t             wr_beat;
  logic [IDX_W-1:0]    wr_idx;
  logic                wr_cnt_hit;
  resp_t               wr_dec_resp, wr_resp;

  axil_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_wr_decode (
    .addr    (wr_addr),
    .idx     (wr_idx),
    .cnt_hit (wr_cnt_hit),
    .resp    (wr_dec_resp)
  );

  always_comb begin
    aw_hs   = AWVALID & awready_q;
    w_hs    = WVALID & wready_q;
    // Whichever half arrived first was latched; the other comes straight from the port.
    wr_addr = (wr_state_q == W_HAVE_A) ? awaddr_q : AWADDR;
    wr_beat = (wr_state_q == W_HAVE_D) ? wbeat_q : WxDATA_t'(WDATA);
    wr_resp = wr_cnt_hit ? SLVERR : wr_dec_resp;
    commit  = ((wr_state_q == W_IDLE)   & aw_hs & w_hs) |
              ((wr_state_q == W_HAVE_A) & w_hs) |
              ((wr_state_q == W_HAVE_D) & aw_hs);

    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs)  wr_state_d = W_RESP;
        else if (aw_hs)     wr_state_d = W_HAVE_A;
        else if (w_hs)      wr_state_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)   wr_state_d = W_RESP;
      W_HAVE_D: if (aw_hs)  wr_state_d = W_RESP;
      W_RESP:   if (BREADY) wr_state_d = W_IDLE;
      default:              wr_state_d = W_IDLE;
    endcase

    awaddr_d  = aw_hs ? AWADDR : awaddr_q;
    wbeat_d   = w_hs ? WxDATA_t'(WDATA) : wbeat_q;
    awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_D);
    wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_A);
    bvalid_d  = (wr_state_d == W_RESP);
    bresp_d   = commit ? wr_resp : bresp_q;

    reg_wr_d = '0;
    regs_d   = regs_q;
    if (commit && (wr_resp == OKAY)) begin
      reg_wr_d[wr_idx] = 1'b1;
      regs_d[wr_idx]   = strb_merge(regs_q[wr_idx], wr_beat);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      awaddr_q   <= '0;
      wbeat_q    <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      reg_wr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      wbeat_q    <= wbeat_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      reg_wr_q   <= reg_wr_d;
      regs_q     <= regs_d;
    end
  end

  // ---------------- read path ----------------
  rd_state_t           rd_state_q, rd_state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  RxDATA_t             rdata_q, rdata_d;
  logic                ar_hs;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_cnt_hit;
  resp_t               rd_resp;
  logic [DATA_LEN-1:0] rd_word;
  logic [DATA_LEN-1:0] cnt_ext;

  axil_addr_decode #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_rd_decode (
    .addr    (ARADDR),
    .idx     (rd_idx),
    .cnt_hit (rd_cnt_hit),
    .resp    (rd_resp)
  );

  always_comb begin
    ar_hs   = ARVALID & arready_q;
    rd_word = rd_cnt_hit ? cnt_ext : regs_q[rd_idx];

    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs)  rd_state_d = R_DATA;
      R_DATA:  if (RREADY) rd_state_d = R_IDLE;
      default:             rd_state_d = R_IDLE;
    endcase

    // Sampling regs_q (not regs_d) gives the pre-write value on a same-cycle collision.
    rdata_d = rdata_q;
    if (ar_hs) begin
      rdata_d.data = (rd_resp == OKAY) ? rd_word : '0;
      rdata_d.resp = rd_resp;
    end
    arready_d = (rd_state_d == R_IDLE);
    rvalid_d  = (rd_state_d == R_DATA);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // ---------------- error counter ----------------
`ifdef AXIL_ERR_CNT_EN
  logic [31:0] err_cnt_q, err_cnt_d;
  logic [1:0]  err_inc;
  logic [32:0] err_sum;

  always_comb begin
    err_inc   = {1'b0, commit && (wr_resp != OKAY)} + {1'b0, ar_hs && (rd_resp != OKAY)};
    err_sum   = {1'b0, err_cnt_q} + {31'b0, err_inc};
    err_cnt_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    cnt_ext   = {{(DATA_LEN-32){1'b0}}, err_cnt_q};
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end
`else
  assign cnt_ext = '0;
`endif

  // ---------------- outputs ----------------
  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign reg_q[i*DATA_LEN +: DATA_LEN] = regs_q[i];
    end
  endgenerate

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign reg_wr  = reg_wr_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_axil_slave_regfile : directed table, corner sequences and random traffic
//                         against a register-array model (default build).
// Revision              : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axil_slave_regfile;
  import axi_helper::*;

  localparam int NR = 8;

  logic                   ACLK = 1'b0;
  logic                   ARESET;
  logic [ADDR_LEN-1:0]    AWADDR, ARADDR;
  logic                   AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic                   AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [WxDATA_W-1:0]    WDATA;
  logic [1:0]             BRESP;
  logic [RxDATA_W-1:0]    RDATA;
  logic [NR*DATA_LEN-1:0] reg_q;
  logic [NR-1:0]          reg_wr;

  axil_slave_regfile #(.NUM_REGS(NR), .BASE_ADDR(32'h0000_0000)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  logic [63:0] model [NR];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    if ((a / 8) >= NR) return 2'b11;
    if ((a % 8) != 0)  return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[i*64 +: 64] = model[i];
    return f;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int da, input int dw, input int bdly, output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    logic [1:0] exp_resp;
    logic [NR-1:0] exp_wr;
    aw_done = 0; w_done = 0; cyc = 0;
    exp_resp = model_resp(a);
    exp_wr = '0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge ACLK);
      if (w_done && !aw_done) check("wready_low_have_d", WREADY, 0);
      if (aw_done && !w_done) check("awready_low_have_a", AWREADY, 0);
      AWVALID = !aw_done && (cyc >= da);
      AWADDR  = a;
      WVALID  = !w_done && (cyc >= dw);
      WDATA   = {d, s};
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(posedge ACLK);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
    end
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    check("write_hs_done", {aw_done, w_done}, 2'b11);
    if (exp_resp == 2'b00) begin
      for (int b = 0; b < 8; b++)
        if (s[b]) model[a/8][b*8 +: 8] = d[b*8 +: 8];
      exp_wr[a/8] = 1'b1;
    end
    check("bvalid_latency", BVALID, 1);
    check("bresp", BRESP, exp_resp);
    check("reg_wr_pulse", reg_wr, exp_wr);
    check("reg_q_after_write", reg_q, model_flat());
    for (int k = 0; k < bdly; k++) begin
      @(negedge ACLK);
      check("b_hold", {BVALID, BRESP, AWREADY, WREADY}, {1'b1, exp_resp, 2'b00});
    end
    resp = BRESP;
    BREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 0;
    check("b_done", {BVALID, AWREADY, WREADY, reg_wr}, {3'b011, {NR{1'b0}}});
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly,
                         output logic [63:0] data, output logic [1:0] resp);
    bit fired;
    int cyc;
    logic [1:0]  exp_resp;
    logic [63:0] exp_data;
    fired = 0; cyc = 0;
    exp_resp = model_resp(a);
    exp_data = (exp_resp == 2'b00) ? model[a/8] : 64'd0;
    while (!fired && cyc < 20) begin
      @(negedge ACLK);
      ARVALID = 1; ARADDR = a;
      fired = ARREADY;
      @(posedge ACLK);
      cyc++;
    end
    @(negedge ACLK);
    ARVALID = 0;
    check("ar_hs_done", fired, 1);
    check("rvalid_latency", RVALID, 1);
    check("rdata", RDATA, {exp_data, exp_resp});
    for (int k = 0; k < rdly; k++) begin
      @(negedge ACLK);
      check("r_hold", {RVALID, ARREADY, RDATA}, {2'b10, exp_data, exp_resp});
    end
    data = RDATA[RxDATA_W-1:2];
    resp = RDATA[1:0];
    RREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    RREADY = 0;
    check("r_done", {RVALID, ARREADY}, 2'b01);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    int          da, dw, bdly, rdly;
    logic [1:0]  bresp;
    logic [63:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [1:0]  br, rr;
    logic [63:0] rd;
    logic [31:0] a;

    vecs[0] = '{32'h10, 64'h1122334455667788, 8'hFF, 0, 0, 5, 0, 2'b00, 64'h1122334455667788, 2'b00};
    vecs[1] = '{32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0, 0, 5, 2'b00, 64'h11223344AAAAAAAA, 2'b00};
    vecs[2] = '{32'h08, 64'hDEADBEEFCAFEF00D, 8'hFF, 3, 0, 1, 1, 2'b00, 64'hDEADBEEFCAFEF00D, 2'b00};
    vecs[3] = '{32'h40, 64'h0123012301230123, 8'hFF, 0, 0, 0, 0, 2'b11, 64'h0,              2'b11};
    vecs[4] = '{32'h14, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 1, 1, 0, 0, 2'b10, 64'h0,              2'b10};
    vecs[5] = '{32'h18, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, 0, 0, 0, 2'b00, 64'h0,              2'b00};
    vecs[6] = '{32'h38, 64'h0123456789ABCDEF, 8'hFF, 0, 2, 2, 2, 2'b00, 64'h0123456789ABCDEF, 2'b00};
    vecs[7] = '{32'h00, 64'hFFEEDDCCBBAA9988, 8'h81, 1, 0, 0, 0, 2'b00, 64'hFF00000000000088, 2'b00};

    for (int i = 0; i < NR; i++) model[i] = '0;
    ARESET = 1; AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
    AWADDR = '0; ARADDR = '0; WDATA = '0;
    repeat (3) @(negedge ACLK);
    check("reset_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    check("reset_valid", {BVALID, RVALID}, 2'b00);
    check("reset_bresp_rdata", {BRESP, RDATA}, '0);
    check("reset_regs", {reg_wr, reg_q}, '0);
    ARESET = 0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].da, vecs[i].dw, vecs[i].bdly, br);
      check($sformatf("tbl%0d_bresp", i), br, vecs[i].bresp);
      do_read(vecs[i].addr, vecs[i].rdly, rd, rr);
      check($sformatf("tbl%0d_rdata", i), {rd, rr}, {vecs[i].rdata, vecs[i].rresp});
    end

    // Same-cycle write commit and read of register 2 returns the old value
    @(negedge ACLK);
    AWVALID = 1; AWADDR = 32'h10; WVALID = 1; WDATA = {64'h5555666677778888, 8'hFF};
    ARVALID = 1; ARADDR = 32'h10;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    check("collision_rdata", RDATA, {64'h11223344AAAAAAAA, 2'b00});
    model[2] = 64'h5555666677778888;
    check("collision_reg", reg_q, model_flat());
    check("collision_valids", {BVALID, RVALID}, 2'b11);
    BREADY = 1; RREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 0; RREADY = 0;
    check("collision_done", {BVALID, RVALID}, 2'b00);

    // Reset while holding an address-only write and an unaccepted read beat
    @(negedge ACLK);
    AWVALID = 1; AWADDR = 32'h08; ARVALID = 1; ARADDR = 32'h00;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 0; ARVALID = 0;
    check("pre_reset_state", {AWREADY, WREADY, RVALID, ARREADY}, 4'b0110);
    #2 ARESET = 1;
    #1;
    check("async_reset_valids", {BVALID, RVALID}, 2'b00);
    check("async_reset_regs", reg_q, '0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge ACLK);
    ARESET = 0;
    @(negedge ACLK);
    check("post_reset_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    do_write(32'h08, 64'h0F0E0D0C0B0A0908, 8'hFF, 0, 0, 0, br);
    check("post_reset_bresp", br, 2'b00);
    do_read(32'h08, 0, rd, rr);
    check("post_reset_rdata", rd, 64'h0F0E0D0C0B0A0908);

    // Random traffic against the model
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 7) a = {$urandom_range(0, NR-1), 3'b000};
      else                          a = $urandom_range(0, 127);
      if ($urandom_range(0, 1) == 0)
        do_write(a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), br);
      else
        do_read(a, $urandom_range(0, 2), rd, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
